la_probe_capture: RTL and testbench

- Downstream stage of the 15-bit probe/test-output bus. Samples the bus every clock, waits for a masked pattern trigger, and stores pre- and post-trigger history in a circular buffer.
- After capture, streams the stored samples oldest-first over a valid/ready interface to the host-readout logic.
- Also reports where the trigger sample sits in that stream.

---
 rtl/la_probe_capture.sv | 261 ++++++++++++++++++++++++++
 tb/tb_la_probe_capture.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/la_probe_capture.sv
// la_probe_capture: samples the probe bus, waits for a masked trigger,
// keeps pre/post history in a circular buffer and streams it oldest-first.
// Ports:
//   clk, rst_n                 capture clock, async active-low reset
//   probe_in                   asynchronous probe bus (synchronized here)
//   arm, abort                 start a capture / return to idle
//   trig_mask, trig_value      masked compare pattern
//   trig_edge                  0 = level, 1 = entry-into-match
//   post_count                 samples stored after the trigger sample
//   out_valid/out_data/out_last/out_ready  readout stream
//   armed, triggered, trig_index           capture status
module la_probe_capture #(
    parameter int WIDTH       = 15,
    parameter int ADDR_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WIDTH-1:0]  probe_in,
    input  logic              arm,
    input  logic              abort,
    input  logic [WIDTH-1:0]  trig_mask,
    input  logic [WIDTH-1:0]  trig_value,
    input  logic              trig_edge,
    input  logic [ADDR_W-1:0] post_count,
    output logic              out_valid,
    output logic [WIDTH-1:0]  out_data,
    output logic              out_last,
    input  logic              out_ready,
    output logic              armed,
    output logic              triggered,
    output logic [ADDR_W-1:0] trig_index
);

    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic [1:0] {
        S_IDLE,
        S_PRE,
        S_POST,
        S_READ
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // Input synchronizer
    logic [WIDTH-1:0] r_sync [SYNC_STAGES];
    logic [WIDTH-1:0] w_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_sync[i] <= '0;
            end
        end else begin
            r_sync[0] <= probe_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
        end
    end

    assign w_s = r_sync[SYNC_STAGES-1];

    // Capture-side registers
    logic [WIDTH-1:0]  r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wr_ptr;
    logic              r_wrapped;
    logic [ADDR_W-1:0] r_trig_addr;
    logic [ADDR_W-1:0] r_post_cnt;
    logic              r_prev_match;
    logic              r_triggered;
    logic [ADDR_W-1:0] r_trig_index;

    // Readout-side registers
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_fetch_left;
    logic [WIDTH-1:0]  r_ram_q;
    logic              r_ram_valid;
    logic              r_ram_last;
    logic              r_skid_valid;
    logic [WIDTH-1:0]  r_skid_data;
    logic              r_skid_last;
    logic              r_out_valid;
    logic [WIDTH-1:0]  r_out_data;
    logic              r_out_last;

    logic              w_match;
    logic              w_arm_go;
    logic              w_fire;
    logic              w_we;
    logic [ADDR_W-1:0] w_post_eff;
    logic [ADDR_W-1:0] w_wr_ptr_inc;
    logic              w_wrapped_nxt;
    logic [ADDR_W-1:0] w_trig_addr_nxt;
    logic [ADDR_W-1:0] w_start;
    logic [ADDR_W:0]   w_n;
    logic              w_enter_read;
    logic              w_xfer;
    logic              w_rd_done;
    logic [1:0]        w_occ;
    logic              w_issue;

    assign w_match  = ((w_s ^ trig_value) & trig_mask) == '0;
    assign w_arm_go = (r_state == S_IDLE) & arm & ~abort;
    assign w_fire   = (r_state == S_PRE) & ~abort &
                      (trig_edge ? (w_match & ~r_prev_match) : w_match);
    assign w_we     = ((r_state == S_PRE) | (r_state == S_POST)) & ~abort;

    // post_count is ADDR_W bits wide, so it can never exceed DEPTH-1:
    // the trigger sample is always the oldest sample that can survive.
    assign w_post_eff = post_count;

    // Values as they will be after this cycle's write; used at READ entry
    assign w_wr_ptr_inc    = r_wr_ptr + 1'b1;
    assign w_wrapped_nxt   = r_wrapped | (r_wr_ptr == '1);
    assign w_trig_addr_nxt = w_fire ? r_wr_ptr : r_trig_addr;
    assign w_start         = w_wrapped_nxt ? w_wr_ptr_inc : '0;
    assign w_n             = w_wrapped_nxt ? (ADDR_W+1)'(DEPTH)
                                           : {1'b0, w_wr_ptr_inc};

    assign w_xfer    = r_out_valid & out_ready;
    assign w_rd_done = w_xfer & r_out_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: if (arm) w_state_nxt = S_PRE;
            S_PRE: begin
                if (w_fire) begin
                    w_state_nxt = (w_post_eff == '0) ? S_READ : S_POST;
                end
            end
            S_POST: if (r_post_cnt == ADDR_W'(1)) w_state_nxt = S_READ;
            S_READ: if (w_rd_done) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
        if (abort) w_state_nxt = S_IDLE;
    end

    assign w_enter_read = (w_state_nxt == S_READ) & (r_state != S_READ);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr     <= '0;
            r_wrapped    <= 1'b0;
            r_trig_addr  <= '0;
            r_post_cnt   <= '0;
            r_prev_match <= 1'b0;
            r_triggered  <= 1'b0;
            r_trig_index <= '0;
        end else begin
            r_prev_match <= w_arm_go ? 1'b0 : w_match;
            if (w_arm_go) begin
                r_wr_ptr     <= '0;
                r_wrapped    <= 1'b0;
                r_triggered  <= 1'b0;
                r_trig_index <= '0;
            end else if (w_we) begin
                r_wr_ptr  <= w_wr_ptr_inc;
                r_wrapped <= w_wrapped_nxt;
            end
            if (w_fire) begin
                r_trig_addr <= r_wr_ptr;
                r_triggered <= 1'b1;
                r_post_cnt  <= w_post_eff;
            end else if ((r_state == S_POST) & w_we) begin
                r_post_cnt <= r_post_cnt - 1'b1;
            end
            if (w_enter_read) begin
                r_trig_index <= w_trig_addr_nxt - w_start;
            end
        end
    end

    // Buffer: synchronous write, registered read
    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem[r_wr_ptr] <= w_s;
        end
        r_ram_q <= r_mem[r_rd_ptr];
    end

    // Items held or in flight (output + skid + RAM read) after this
    // cycle's transfer; a new read may only start if a slot stays free.
    assign w_occ = {1'b0, r_out_valid} + {1'b0, r_skid_valid} +
                   {1'b0, r_ram_valid} - {1'b0, w_xfer};
    assign w_issue = (r_state == S_READ) & ~abort &
                     (r_fetch_left != '0) & (w_occ < 2'd2);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr     <= '0;
            r_fetch_left <= '0;
            r_ram_valid  <= 1'b0;
            r_ram_last   <= 1'b0;
            r_skid_valid <= 1'b0;
            r_skid_data  <= '0;
            r_skid_last  <= 1'b0;
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_out_last   <= 1'b0;
        end else if ((r_state != S_READ) | abort) begin
            r_ram_valid  <= 1'b0;
            r_ram_last   <= 1'b0;
            r_skid_valid <= 1'b0;
            r_out_valid  <= 1'b0;
            r_out_last   <= 1'b0;
            if (w_enter_read) begin
                r_rd_ptr     <= w_start;
                r_fetch_left <= w_n;
            end else begin
                r_fetch_left <= '0;
            end
        end else begin
            if (w_issue) begin
                r_rd_ptr     <= r_rd_ptr + 1'b1;
                r_fetch_left <= r_fetch_left - 1'b1;
            end
            r_ram_valid <= w_issue;
            r_ram_last  <= w_issue & (r_fetch_left == (ADDR_W+1)'(1));
            if (~r_out_valid | out_ready) begin
                if (r_skid_valid) begin
                    r_out_valid  <= 1'b1;
                    r_out_data   <= r_skid_data;
                    r_out_last   <= r_skid_last;
                    r_skid_valid <= r_ram_valid;
                    r_skid_data  <= r_ram_q;
                    r_skid_last  <= r_ram_last;
                end else begin
                    r_out_valid <= r_ram_valid;
                    r_out_last  <= r_ram_valid & r_ram_last;
                    if (r_ram_valid) begin
                        r_out_data <= r_ram_q;
                    end
                end
            end else if (r_ram_valid) begin
                r_skid_valid <= 1'b1;
                r_skid_data  <= r_ram_q;
                r_skid_last  <= r_ram_last;
            end
        end
    end

    assign out_valid  = r_out_valid;
    assign out_data   = r_out_data;
    assign out_last   = r_out_last;
    assign armed      = (r_state == S_PRE) | (r_state == S_POST);
    assign triggered  = r_triggered;
    assign trig_index = r_trig_index;

endmodule

// File: tb/tb_la_probe_capture.sv
// tb_la_probe_capture: directed bench for la_probe_capture.
// Drives capture scenarios and checks the readout stream and status.
module tb_la_probe_capture;

    localparam int W  = 15;
    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [W-1:0]  probe_in;
    logic          arm;
    logic          abort;
    logic [W-1:0]  trig_mask;
    logic [W-1:0]  trig_value;
    logic          trig_edge;
    logic [AW-1:0] post_count;
    logic          out_valid;
    logic [W-1:0]  out_data;
    logic          out_last;
    logic          out_ready;
    logic          armed;
    logic          triggered;
    logic [AW-1:0] trig_index;

    int n_cmp = 0;
    int n_bad = 0;

    logic [W-1:0] stim[$];
    logic [W-1:0] expq[$];
    int           arm_extra;

    la_probe_capture #(
        .WIDTH      (W),
        .ADDR_W     (AW),
        .SYNC_STAGES(2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .probe_in   (probe_in),
        .arm        (arm),
        .abort      (abort),
        .trig_mask  (trig_mask),
        .trig_value (trig_value),
        .trig_edge  (trig_edge),
        .post_count (post_count),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_last   (out_last),
        .out_ready  (out_ready),
        .armed      (armed),
        .triggered  (triggered),
        .trig_index (trig_index)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg(input logic [W-1:0] m, input logic [W-1:0] v,
                       input logic e, input logic [AW-1:0] p);
        trig_mask  = m;
        trig_value = v;
        trig_edge  = e;
        post_count = p;
    endtask

    // stim[k] is the k-th stored sample: it is driven two edges before the
    // PRE cycle that writes it, so stim[0] goes out one cycle before arm.
    task automatic feed();
        int nit;
        nit = (stim.size() < 2) ? 2 : stim.size();
        for (int i = 0; i < nit; i++) begin
            probe_in = (i < stim.size()) ? stim[i] : '0;
            arm      = (i == 1) || (i == arm_extra);
            tick();
        end
        arm       = 1'b0;
        arm_extra = -1;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_data"}, 32'(out_data), 32'd0);
        chk({tag, "_last"}, 32'(out_last), 32'd0);
        chk({tag, "_armed"}, 32'(armed), 32'd0);
        chk({tag, "_trig"}, 32'(triggered), 32'd0);
        chk({tag, "_tidx"}, 32'(trig_index), 32'd0);
    endtask

    // Collect beats against expq; stop_after > 0 leaves the stream partial.
    task automatic collect(input int duty, input int exp_trig,
                           input int stop_after, input string tag);
        int got   = 0;
        int cyc   = 0;
        int first = -1;
        int lastc = -1;
        int limit;
        logic hold = 1'b0;
        logic [W-1:0] hold_d;
        logic hold_l;
        limit = (stop_after > 0) ? stop_after : expq.size();
        while (got < limit && cyc < 3000) begin
            out_ready = ($urandom_range(99) < duty);
            @(negedge clk);
            if (hold) begin
                chk({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
                chk({tag, "_hold_data"}, 32'(out_data), 32'(hold_d));
                chk({tag, "_hold_last"}, 32'(out_last), 32'(hold_l));
            end
            hold = 1'b0;
            if (out_valid) begin
                if (first < 0) begin
                    first = cyc;
                    chk({tag, "_tidx"}, 32'(trig_index), 32'(exp_trig));
                    chk({tag, "_trig"}, 32'(triggered), 32'd1);
                end
                if (out_ready) begin
                    chk({tag, "_data"}, 32'(out_data), 32'(expq[got]));
                    chk({tag, "_last"}, 32'(out_last),
                        32'(got == expq.size() - 1));
                    got++;
                    lastc = cyc;
                end else begin
                    hold   = 1'b1;
                    hold_d = out_data;
                    hold_l = out_last;
                end
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        out_ready = 1'b0;
        chk({tag, "_count"}, 32'(got), 32'(limit));
        if (stop_after == 0) begin
            if (duty >= 100) begin
                chk({tag, "_rate"}, 32'(lastc - first + 1), 32'(limit));
            end
            @(negedge clk);
            chk({tag, "_end_valid"}, 32'(out_valid), 32'd0);
            chk({tag, "_end_armed"}, 32'(armed), 32'd0);
            chk({tag, "_end_tidx"}, 32'(trig_index), 32'(exp_trig));
            @(posedge clk);
            #1;
        end
    endtask

    task automatic setup_basic();
        cfg(15'h7FFF, 15'h1234, 1'b0, 8'd3);
        stim.delete();
        for (int i = 0; i < 10; i++) stim.push_back(15'h0000);
        stim.push_back(15'h1234);
        stim.push_back(15'h0001);
        stim.push_back(15'h0002);
        stim.push_back(15'h0003);
        expq = stim;
    endtask

    initial begin
        rst_n     = 1'b0;
        probe_in  = '0;
        arm       = 1'b0;
        abort     = 1'b0;
        out_ready = 1'b0;
        arm_extra = -1;
        cfg('0, '0, 1'b0, '0);
        #2;
        check_zero("reset");
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        // Level trigger, full-rate readout
        setup_basic();
        feed();
        collect(100, 10, 0, "level");

        // Edge trigger with wrap: bit0 rises only at sample 305
        cfg(15'h0001, 15'h0001, 1'b1, 8'd10);
        stim.delete();
        for (int k = 0; k < 316; k++) begin
            stim.push_back({k[13:0], (k >= 305) ? 1'b1 : 1'b0});
        end
        expq.delete();
        for (int k = 60; k < 316; k++) expq.push_back(stim[k]);
        feed();
        collect(100, 245, 0, "wrap");

        // Edge mode: prev_match cleared by arm, so a held match fires at 0
        cfg(15'h0001, 15'h0001, 1'b1, 8'd2);
        probe_in = 15'h0001;
        repeat (4) tick();
        stim = '{15'h0003, 15'h0005, 15'h0007};
        expq = stim;
        feed();
        collect(100, 0, 0, "edge0");

        // Mask 0, post 255: 256 samples
        cfg('0, '0, 1'b0, 8'd255);
        stim.delete();
        for (int k = 0; k < 256; k++) stim.push_back(15'(k + 'h100));
        expq = stim;
        feed();
        collect(100, 0, 0, "post255");

        // Mask 0, post 0: a single sample
        cfg('0, '0, 1'b0, 8'd0);
        stim = '{15'h7ABC};
        expq = stim;
        feed();
        collect(100, 0, 0, "post0");

        // Backpressure at ~30% ready
        cfg(15'h7FFF, 15'h7FFF, 1'b0, 8'd19);
        stim.delete();
        for (int k = 0; k < 40; k++) begin
            stim.push_back((k == 20) ? 15'h7FFF : 15'((k * 37) & 'h3FFF));
        end
        expq = stim;
        feed();
        collect(30, 20, 0, "bp");

        // arm during POST is ignored
        cfg('0, '0, 1'b0, 8'd4);
        stim = '{15'h0011, 15'h0022, 15'h0033, 15'h0044, 15'h0055};
        expq = stim;
        arm_extra = 3;
        feed();
        collect(100, 0, 0, "armpost");

        // abort in PRE, then a normal capture
        cfg(15'h7FFF, 15'h7FFF, 1'b0, 8'd3);
        probe_in = '0;
        arm = 1'b1;
        tick();
        arm = 1'b0;
        repeat (3) tick();
        chk("pre_armed", 32'(armed), 32'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        @(negedge clk);
        chk("abpre_armed", 32'(armed), 32'd0);
        chk("abpre_valid", 32'(out_valid), 32'd0);
        tick();
        setup_basic();
        feed();
        collect(100, 10, 0, "after_abpre");

        // abort in POST
        cfg('0, '0, 1'b0, 8'd50);
        stim.delete();
        for (int k = 0; k < 8; k++) stim.push_back(15'(k));
        feed();
        chk("post_armed", 32'(armed), 32'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        @(negedge clk);
        chk("abpost_armed", 32'(armed), 32'd0);
        chk("abpost_valid", 32'(out_valid), 32'd0);
        chk("abpost_trig", 32'(triggered), 32'd1);
        tick();

        // abort mid-READ after 5 beats
        setup_basic();
        feed();
        collect(100, 10, 5, "rd5");
        abort = 1'b1;
        tick();
        abort = 1'b0;
        @(negedge clk);
        chk("abrd_valid", 32'(out_valid), 32'd0);
        chk("abrd_armed", 32'(armed), 32'd0);
        chk("abrd_trig", 32'(triggered), 32'd1);
        chk("abrd_tidx", 32'(trig_index), 32'd10);
        out_ready = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        chk("abrd_quiet", 32'(out_valid), 32'd0);
        out_ready = 1'b0;
        tick();
        setup_basic();
        feed();
        collect(100, 10, 0, "after_abrd");

        // async reset mid-POST
        cfg('0, '0, 1'b0, 8'd50);
        stim.delete();
        for (int k = 0; k < 8; k++) stim.push_back(15'(k + 1));
        feed();
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("rstpost");
        tick();
        rst_n = 1'b1;
        tick();

        // async reset mid-READ
        setup_basic();
        feed();
        collect(100, 10, 3, "rd3");
        out_ready = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("rstread");
        tick();
        rst_n = 1'b1;
        tick();
        @(negedge clk);
        chk("rstread_quiet", 32'(out_valid), 32'd0);
        out_ready = 1'b0;
        tick();

        // first capture after reset
        setup_basic();
        feed();
        collect(100, 10, 0, "after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
